// File: rtl/ir_sweep_sched.sv
`default_nettype none
// ============================================================================
// Module      : ir_sweep_sched
// Description : Sequences one sweep of three IR emitter/receiver pairs.
//               For each pair (inner, middle, outer) the emitter is enabled
//               and left to settle. The right channel is then converted,
//               followed by the left channel. Each result is latched into
//               its reading register.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               go                          - sweep request (sampled in IDLE)
//               strt_cnv, chnnl             - A2D start pulse / channel select
//               cnv_cmplt, res              - A2D done strobe / 12-bit result
//               IR_in_en/IR_mid_en/IR_out_en- one-hot registered emitter enables
//               lft_*/rht_*                 - latest 12-bit readings
//               busy, sweep_done            - status / one-cycle sweep pulse
//               err                         - signed steering error
// Options     : define IR_ERR_EN to compute err in DONE. Without it, err
//               is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module ir_sweep_sched #(
  parameter int SETTLE_CYC = 4096
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  output logic               strt_cnv,
  output logic [2:0]         chnnl,
  input  logic               cnv_cmplt,
  input  logic [11:0]        res,
  output logic               IR_in_en,
  output logic               IR_mid_en,
  output logic               IR_out_en,
  output logic [11:0]        lft_in,
  output logic [11:0]        rht_in,
  output logic [11:0]        lft_mid,
  output logic [11:0]        rht_mid,
  output logic [11:0]        lft_out,
  output logic [11:0]        rht_out,
  output logic               busy,
  output logic               sweep_done,
  output logic signed [15:0] err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETTLE = 3'd1;
  localparam logic [2:0] CNV_R  = 3'd2;
  localparam logic [2:0] WAIT_R = 3'd3;
  localparam logic [2:0] CNV_L  = 3'd4;
  localparam logic [2:0] WAIT_L = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  localparam int              CW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0]   SETTLE_LAST = CW'(SETTLE_CYC - 1);

  logic [2:0]    r_state;
  logic [1:0]    r_pair;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_en;     // one-hot: [0]=inner, [1]=middle, [2]=outer

  // Channel map per pair: inner R1/L0, middle R4/L2, outer R3/L7
  function automatic logic [2:0] rch_of(input logic [1:0] p);
    case (p)
      2'd0:    rch_of = 3'd1;
      2'd1:    rch_of = 3'd4;
      default: rch_of = 3'd3;
    endcase
  endfunction

  function automatic logic [2:0] lch_of(input logic [1:0] p);
    case (p)
      2'd0:    lch_of = 3'd0;
      2'd1:    lch_of = 3'd2;
      default: lch_of = 3'd7;
    endcase
  endfunction

  assign strt_cnv   = (r_state == CNV_R) || (r_state == CNV_L);
  assign busy       = (r_state != IDLE);
  assign sweep_done = (r_state == DONE);
  assign IR_in_en   = r_en[0];
  assign IR_mid_en  = r_en[1];
  assign IR_out_en  = r_en[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pair  <= 2'd0;
      r_cnt   <= '0;
      r_en    <= 3'b000;
      chnnl   <= 3'd0;
      lft_in  <= 12'h000;
      rht_in  <= 12'h000;
      lft_mid <= 12'h000;
      rht_mid <= 12'h000;
      lft_out <= 12'h000;
      rht_out <= 12'h000;
    end else begin
      case (r_state)
        IDLE: begin
          if (go) begin
            r_pair  <= 2'd0;
            r_en    <= 3'b001;
            r_cnt   <= '0;
            r_state <= SETTLE;
          end
        end
        SETTLE: begin
          if (r_cnt == SETTLE_LAST) begin
            chnnl   <= rch_of(r_pair);
            r_state <= CNV_R;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        CNV_R: r_state <= WAIT_R;
        WAIT_R: begin
          if (cnv_cmplt) begin
            case (r_pair)
              2'd0:    rht_in  <= res;
              2'd1:    rht_mid <= res;
              default: rht_out <= res;
            endcase
            chnnl   <= lch_of(r_pair);
            r_state <= CNV_L;
          end
        end
        CNV_L: r_state <= WAIT_L;
        WAIT_L: begin
          if (cnv_cmplt) begin
            case (r_pair)
              2'd0:    lft_in  <= res;
              2'd1:    lft_mid <= res;
              default: lft_out <= res;
            endcase
            if (r_pair == 2'd2) begin
              r_en    <= 3'b000;
              r_state <= DONE;
            end else begin
              // Old enable drops and the next one rises on the same edge,
              // so the enables never overlap.
              r_en    <= {r_en[1:0], 1'b0};
              r_pair  <= r_pair + 2'd1;
              r_cnt   <= '0;
              r_state <= SETTLE;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef IR_ERR_EN
  logic signed [15:0] w_d_in;
  logic signed [15:0] w_d_mid;
  logic signed [15:0] w_d_out;
  logic signed [15:0] w_err;

  // Worst-case magnitude is 45045, which exceeds the signed 16-bit range.
  // The result therefore wraps modulo 2^16.
  always_comb begin
    w_d_in  = $signed({4'h0, rht_in})  - $signed({4'h0, lft_in});
    w_d_mid = $signed({4'h0, rht_mid}) - $signed({4'h0, lft_mid});
    w_d_out = $signed({4'h0, rht_out}) - $signed({4'h0, lft_out});
    w_err   = w_d_in + (w_d_mid <<< 1) + (w_d_out <<< 3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 16'sh0000;
    end else if (r_state == DONE) begin
      err <= w_err;
    end
  end
`else
  assign err = 16'sh0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ir_sweep_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_sweep_sched
// Description : Self-checking bench for ir_sweep_sched.
//               The bench contains an A2D responder model. A scoreboard
//               queue holds the expected channel order for each sweep.
//               Each sweep_done pulse triggers a comparison of the readings
//               against the A2D model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_sweep_sched;

  localparam int SETTLE  = 16;
  localparam int ADC_LAT = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               go = 1'b0;
  logic               cnv_cmplt = 1'b0;
  logic [11:0]        res = 12'h000;
  logic               strt_cnv;
  logic [2:0]         chnnl;
  logic               IR_in_en, IR_mid_en, IR_out_en;
  logic [11:0]        lft_in, rht_in, lft_mid, rht_mid, lft_out, rht_out;
  logic               busy, sweep_done;
  logic signed [15:0] err;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;

  logic [11:0] adc_val [8];
  logic [2:0]  exp_ch_q [$];
  logic [2:0]  adc_ch;
  logic [11:0] rd [6];
  int          rd_ch [6] = '{0, 1, 2, 4, 7, 3};

  assign rd[0] = lft_in;
  assign rd[1] = rht_in;
  assign rd[2] = lft_mid;
  assign rd[3] = rht_mid;
  assign rd[4] = lft_out;
  assign rd[5] = rht_out;

  ir_sweep_sched #(.SETTLE_CYC(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .strt_cnv(strt_cnv), .chnnl(chnnl),
    .cnv_cmplt(cnv_cmplt), .res(res), .IR_in_en(IR_in_en),
    .IR_mid_en(IR_mid_en), .IR_out_en(IR_out_en), .lft_in(lft_in),
    .rht_in(rht_in), .lft_mid(lft_mid), .rht_mid(rht_mid),
    .lft_out(lft_out), .rht_out(rht_out), .busy(busy),
    .sweep_done(sweep_done), .err(err)
  );

  always #5 clk = ~clk;

  // A2D model: each start pulse is answered ADC_LAT cycles later
  initial begin
    forever begin
      @(negedge clk);
      if (strt_cnv && rst_n) begin
        adc_ch = chnnl;
        repeat (ADC_LAT) @(posedge clk);
        #1;
        res       = adc_val[adc_ch];
        cnv_cmplt = 1'b1;
        @(posedge clk);
        #1;
        cnv_cmplt = 1'b0;
      end
    end
  end

  // Monitor: channel-order scoreboard, readings at sweep_done, enable exclusivity
  always @(negedge clk) begin
    if (rst_n) begin
      if ($countones({IR_in_en, IR_mid_en, IR_out_en}) > 1) begin
        tests_failed++;
        $display("FAIL onehot_en: got %b%b%b, want at most one set", IR_out_en, IR_mid_en, IR_in_en);
      end
      if (strt_cnv) begin
        tests_run++;
        if (exp_ch_q.size() == 0) begin
          tests_failed++;
          $display("FAIL chnnl_order: unexpected strt_cnv on ch %0d, none expected", chnnl);
        end else begin
          if (chnnl !== exp_ch_q[0]) begin
            tests_failed++;
            $display("FAIL chnnl_order: got ch %0d, want ch %0d", chnnl, exp_ch_q[0]);
          end
          void'(exp_ch_q.pop_front());
        end
      end
      if (sweep_done) begin
        done_cnt++;
        for (int k = 0; k < 6; k++) begin
          tests_run++;
          if (rd[k] !== adc_val[rd_ch[k]]) begin
            tests_failed++;
            $display("FAIL reading[%0d]: got 0x%03h, want 0x%03h", k, rd[k], adc_val[rd_ch[k]]);
          end
        end
      end
    end
  end

  function automatic logic [15:0] exp_err();
`ifdef IR_ERR_EN
    int e;
    e = (int'(adc_val[1]) - int'(adc_val[0]))
      + 2 * (int'(adc_val[4]) - int'(adc_val[2]))
      + 8 * (int'(adc_val[3]) - int'(adc_val[7]));
    return e[15:0];
`else
    return 16'h0000;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_adc(input logic [11:0] c0, c1, c2, c3, c4, c7);
    for (int k = 0; k < 8; k++) adc_val[k] = 12'h000;
    adc_val[0] = c0; adc_val[1] = c1; adc_val[2] = c2;
    adc_val[3] = c3; adc_val[4] = c4; adc_val[7] = c7;
  endtask

  task automatic start_sweep();
    exp_ch_q.push_back(3'd1); exp_ch_q.push_back(3'd0);
    exp_ch_q.push_back(3'd4); exp_ch_q.push_back(3'd2);
    exp_ch_q.push_back(3'd3); exp_ch_q.push_back(3'd7);
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (sweep_done) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL sweep_timeout: no sweep_done within %0d cycles", budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    go    = 1'b0;
    repeat (3) tick();
    tests_run++;
    if ({IR_in_en, IR_mid_en, IR_out_en, strt_cnv, busy, sweep_done} !== 6'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: got en/strt/busy/done=%b, want 000000",
               {IR_in_en, IR_mid_en, IR_out_en, strt_cnv, busy, sweep_done});
    end
    tests_run++;
    if (chnnl !== 3'd0 || err !== 16'sh0000) begin
      tests_failed++;
      $display("FAIL reset_chnnl_err: got chnnl=%0d err=0x%04h, want 0/0x0000", chnnl, err);
    end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (rd[k] !== 12'h000) begin
        tests_failed++;
        $display("FAIL reset_reading[%0d]: got 0x%03h, want 0x000", k, rd[k]);
      end
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_sweep();
    int d0;
    set_adc(12'h080, 12'h100, 12'h200, 12'h050, 12'h200, 12'h010);
    d0 = done_cnt;
    start_sweep();
    wait_done(1000);
    tick();
    tests_run++;
    if (done_cnt - d0 !== 1) begin
      tests_failed++;
      $display("FAIL basic_done_count: got %0d pulses, want 1", done_cnt - d0);
    end
    tests_run++;
    if (busy !== 1'b0 || sweep_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_idle: got busy=%b done=%b, want 0/0", busy, sweep_done);
    end
    tests_run++;
    if (err !== exp_err()) begin
      tests_failed++;
      $display("FAIL basic_err: got 0x%04h, want 0x%04h", err, exp_err());
    end
    tests_run++;
    if (exp_ch_q.size() != 0) begin
      tests_failed++;
      $display("FAIL basic_conversions: got %0d conversions missing, want 0", exp_ch_q.size());
    end
  endtask

  task automatic test_settle_timing();
    int first_en, first_strt;
    first_en   = -1;
    first_strt = -1;
    exp_ch_q.push_back(3'd1); exp_ch_q.push_back(3'd0);
    exp_ch_q.push_back(3'd4); exp_ch_q.push_back(3'd2);
    exp_ch_q.push_back(3'd3); exp_ch_q.push_back(3'd7);
    go = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      go = 1'b0;
      if (IR_in_en && first_en < 0) first_en = i;
      if (strt_cnv) begin
        first_strt = i;
        break;
      end
    end
    tests_run++;
    if (first_en < 0 || first_strt < 0 || (first_strt - first_en) != SETTLE) begin
      tests_failed++;
      $display("FAIL settle_time: got en@%0d strt@%0d, want gap %0d", first_en, first_strt, SETTLE);
    end
    wait_done(1000);
    tick();
  endtask

  task automatic test_go_during_sweep();
    int d0;
    d0 = done_cnt;
    set_adc(12'h123, 12'h456, 12'h789, 12'hABC, 12'hDEF, 12'h321);
    start_sweep();
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (sweep_done) begin
        go = 1'b1;
        tick();
        go = 1'b0;
        tests_run++;
        if (busy !== 1'b0) begin
          tests_failed++;
          $display("FAIL busy_fall: got busy=%b after sweep_done, want 0", busy);
        end
        break;
      end
      go = (i % 7 == 0);
    end
    go = 1'b0;
    repeat (40) tick();
    tests_run++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL go_ignored: got %0d pulses busy=%b, want 1 pulse busy=0", done_cnt - d0, busy);
    end
    exp_ch_q.delete();
  endtask

  task automatic test_cmplt_in_settle();
    int n;
    bit early;
    early = 1'b0;
    exp_ch_q.push_back(3'd1); exp_ch_q.push_back(3'd0);
    exp_ch_q.push_back(3'd4); exp_ch_q.push_back(3'd2);
    exp_ch_q.push_back(3'd3); exp_ch_q.push_back(3'd7);
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (2) tick();
    cnv_cmplt = 1'b1;
    res       = 12'hABC;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (strt_cnv) early = 1'b1;
    end
    cnv_cmplt = 1'b0;
    tests_run++;
    if (early || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL settle_cmplt_state: got early_strt=%b busy=%b, want 0/1", early, busy);
    end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (rd[k] !== adc_val[rd_ch[k]]) begin
        tests_failed++;
        $display("FAIL settle_cmplt_hold[%0d]: got 0x%03h, want 0x%03h", k, rd[k], adc_val[rd_ch[k]]);
      end
    end
    n = 10;
    while (!strt_cnv && n < 100) begin
      tick();
      n++;
    end
    tests_run++;
    if (n != SETTLE) begin
      tests_failed++;
      $display("FAIL settle_cmplt_timing: got first strt at %0d, want %0d", n, SETTLE);
    end
    wait_done(1000);
    tick();
  endtask

  task automatic test_reset_mid_sweep();
    int d0;
    bit found;
    found = 1'b0;
    set_adc(12'h011, 12'h022, 12'h033, 12'h044, 12'h055, 12'h066);
    d0 = done_cnt;
    start_sweep();
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (strt_cnv && chnnl == 3'd2) begin
        found = 1'b1;
        break;
      end
    end
    repeat (3) tick();
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (!found || {IR_in_en, IR_mid_en, IR_out_en, busy, strt_cnv} !== 5'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_ctrl: got found=%b en/busy/strt=%b, want 1/00000", found,
               {IR_in_en, IR_mid_en, IR_out_en, busy, strt_cnv});
    end
    for (int k = 0; k < 6; k++) begin
      tests_run++;
      if (rd[k] !== 12'h000) begin
        tests_failed++;
        $display("FAIL rst_mid_reading[%0d]: got 0x%03h, want 0x000", k, rd[k]);
      end
    end
    exp_ch_q.delete();
    repeat (20) tick();
    rst_n = 1'b1;
    tick();
    tests_run++;
    if (done_cnt !== d0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_done: got %0d pulses, want 0", done_cnt - d0);
    end
    start_sweep();
    wait_done(1000);
    tick();
    tests_run++;
    if (done_cnt - d0 !== 1 || err !== exp_err()) begin
      tests_failed++;
      $display("FAIL rst_mid_clean: got pulses=%0d err=0x%04h, want 1/0x%04h",
               done_cnt - d0, err, exp_err());
    end
  endtask

  task automatic test_err_extreme();
    set_adc(12'hFFF, 12'h000, 12'hFFF, 12'h000, 12'h000, 12'hFFF);
    start_sweep();
    wait_done(1000);
    tick();
    tests_run++;
    if (err !== exp_err()) begin
      tests_failed++;
      $display("FAIL err_extreme: got 0x%04h, want 0x%04h", err, exp_err());
    end
  endtask

  initial begin
    set_adc(12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000);
    test_reset();
    test_basic_sweep();
    test_settle_timing();
    test_go_during_sweep();
    test_cmplt_in_settle();
    test_reset_mid_sweep();
    test_err_extreme();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
`default_nettype wire
